// File: rtl/route_scheduler_if.sv
// Load and navigation-FSM command bundle between the user layer, the
// route scheduler and the semi-auto navigation FSM.
interface route_scheduler_if;
    logic       load_valid;
    logic [1:0] load_cmd;
    logic       load_ready;
    logic [1:0] nav_state;
    logic       straight;
    logic       left;
    logic       right;
    logic       back;

    modport master (
        output load_valid, load_cmd, nav_state,
        input  load_ready, straight, left, right, back
    );

    modport slave (
        input  load_valid, load_cmd, nav_state,
        output load_ready, straight, left, right, back
    );
endinterface

// File: rtl/route_scheduler.sv
// Route scheduler: FIFO of preloaded turn commands, one presented to the
// semi-auto FSM per crossroad and held until forward motion resumes.
module route_scheduler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             power,
    input  logic [1:0]       global_state,
    input  logic             clear,
    route_scheduler_if.slave bus,
    output logic [PTR_W:0]   count,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_ISSUE   = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]       state, state_nxt;
    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic [3:0]       cmd_q, cmd_nxt;   // {back, right, left, straight}
    logic             load_ready_q;
    logic             popped;
    logic             active, push, pop;

    assign active = power && (global_state == 2'b01 || global_state == 2'b10);
    assign push   = bus.load_valid && load_ready_q;
    // The head leaves the FIFO on the edge that enters ADVANCE, so count
    // is already decremented while ADVANCE is current.
    assign pop    = (state == S_ISSUE) && active && (bus.nav_state == 2'b00);

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + CNT_W'(1);
        else if (pop && !push)
            count_nxt = count - CNT_W'(1);
    end

    // Next state and next command vector
    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        if (!active) begin
            state_nxt = S_IDLE;
            cmd_nxt   = 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    cmd_nxt = 4'b0000;
                    if (count != CNT_W'(0))
                        state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    cmd_nxt = 4'b0000;
                    if (count == CNT_W'(0) && popped) begin
                        state_nxt = S_DONE;
                    end else if (bus.nav_state == 2'b01 && count != CNT_W'(0)) begin
                        state_nxt = S_ISSUE;
                        cmd_nxt   = 4'b0001 << mem[rd_ptr];
                    end
                end
                S_ISSUE: begin
                    if (bus.nav_state == 2'b00) begin
                        state_nxt = S_ADVANCE;
                        cmd_nxt   = 4'b0000;
                    end
                end
                S_ADVANCE: begin
                    cmd_nxt   = 4'b0000;
                    state_nxt = (count_nxt == CNT_W'(0)) ? S_DONE : S_ARMED;
                end
                S_DONE: begin
                    cmd_nxt = 4'b0000;
                    if (push)
                        state_nxt = S_ARMED;
                end
                default: begin
                    state_nxt = S_IDLE;
                    cmd_nxt   = 4'b0000;
                end
            endcase
        end
    end

    // State, pointers and registered outputs
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cmd_q        <= 4'b0000;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            load_ready_q <= 1'b1;
            popped       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else if (clear) begin
            state        <= S_IDLE;
            cmd_q        <= 4'b0000;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            load_ready_q <= 1'b1;
            popped       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cmd_q        <= cmd_nxt;
            count        <= count_nxt;
            load_ready_q <= (count_nxt != CNT_W'(DEPTH));
            busy         <= (state_nxt == S_ISSUE);
            done         <= (state_nxt == S_DONE);
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                popped <= 1'b1;
            end
            if (bus.load_valid && !load_ready_q)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst && !clear && push)
            mem[wr_ptr] <= bus.load_cmd;
    end

    assign bus.load_ready = load_ready_q;
    assign bus.straight   = cmd_q[0];
    assign bus.left       = cmd_q[1];
    assign bus.right      = cmd_q[2];
    assign bus.back       = cmd_q[3];

endmodule
